// File: rtl/key_iv_loader_if.sv
// Word stream carrying key and IV words into the loader.
// A word moves on every rising clk edge where din_valid and din_ready are both 1.
// The source holds din stable while din_valid is high and din_ready is low.
// din_ready may depend combinationally on the loader's control inputs.
interface key_iv_loader_if #(
  parameter int W = 32
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/key_iv_loader.sv
// Word-serial key/IV loader: assembles a 189-bit key and 32-bit IV from a 32-bit stream and
// commits them atomically for the key setup stage, with full-load and IV-only reseed modes.
module key_iv_loader #(
  parameter int KEY_W = 189,
  parameter int IV_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               iv_only,
  input  logic               abort,
  key_iv_loader_if.slave     stream,
  output logic [KEY_W-1:0]   key,
  output logic [IV_W-1:0]    iv,
  output logic               key_valid,
  output logic               load_done,
  output logic               err,
  output logic [1:0]         state_dbg
);

  // Bits of the last key word that land in the key; the rest must be zero.
  localparam int TOP_W = KEY_W - 5 * IV_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    IV   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] staging;
  logic [2:0]       count;
  logic             fmt_err;
  logic             full_load;
  logic             ready;
  logic             start_full;
  logic             start_reseed;
  logic             key_accept;
  logic             iv_accept;

  assign stream.din_ready = ready;
  assign state_dbg        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    start_full   = 1'b0;
    start_reseed = 1'b0;
    key_accept   = 1'b0;
    iv_accept    = 1'b0;
    case (state)
      IDLE: begin
        // A reseed only makes sense on top of a committed key.
        start_full   = start && !iv_only;
        start_reseed = start && iv_only && key_valid;
        if (start_full) begin
          state_next = KEY;
        end else if (start_reseed) begin
          state_next = IV;
        end
      end
      KEY: begin
        ready      = !abort;
        key_accept = ready && stream.din_valid;
        if (abort) begin
          state_next = IDLE;
        end else if (key_accept && count == 3'd5) begin
          state_next = IV;
        end
      end
      IV: begin
        ready     = !abort;
        iv_accept = ready && stream.din_valid;
        if (abort || iv_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= '0;
      iv        <= '0;
      staging   <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
      fmt_err   <= 1'b0;
      full_load <= 1'b0;
    end else begin
      load_done <= 1'b0;

      if (start_full) begin
        count     <= '0;
        key_valid <= 1'b0;
        err       <= 1'b0;
        fmt_err   <= 1'b0;
        full_load <= 1'b1;
      end else if (start_reseed) begin
        err       <= 1'b0;
        fmt_err   <= 1'b0;
        full_load <= 1'b0;
      end

      if (key_accept) begin
        count <= count + 3'd1;
        case (count)
          3'd0: staging[0*IV_W +: IV_W] <= stream.din;
          3'd1: staging[1*IV_W +: IV_W] <= stream.din;
          3'd2: staging[2*IV_W +: IV_W] <= stream.din;
          3'd3: staging[3*IV_W +: IV_W] <= stream.din;
          3'd4: staging[4*IV_W +: IV_W] <= stream.din;
          3'd5: begin
            staging[KEY_W-1:5*IV_W] <= stream.din[TOP_W-1:0];
            if (|stream.din[IV_W-1:TOP_W]) begin
              fmt_err <= 1'b1;
            end
            count <= '0;
          end
          default: count <= '0;
        endcase
      end

      // Commit is all-or-nothing: a malformed load leaves the previous key/iv in place.
      if (iv_accept) begin
        load_done <= 1'b1;
        if (fmt_err) begin
          err <= 1'b1;
        end else begin
          if (full_load) begin
            key <= staging;
          end
          iv        <= stream.din;
          key_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/key_iv_loader.md
Name: key_iv_loader

Overview:
- Word-serial loader that assembles the 189-bit cipher key and the 32-bit IV from a 32-bit valid/ready input stream.
- Presents key and IV as stable parallel buses for the stream-I key setup stage, which XORs them into Xp0/Xs0/Xl0.
- Supports a full key+IV load and an IV-only reseed.
- Key and IV outputs update atomically, only when a load completes without error.

Parameters:
- KEY_W, 189, key width in bits; fixed by the key setup stage.
- IV_W, 32, IV width; also the stream word width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load; sampled only in IDLE
- iv_only  input  1  qualifies start; 1 = reseed (IV word only)
- abort  input  1  cancel an in-progress load
- din  input  32  stream data word
- din_valid  input  1  din holds a valid word
- din_ready  output  1  loader accepts a word this cycle
- key  output  189  committed key (key[31:0]=Xp seed, key[63:32]=Xs seed, key[95:64]=Xl seed)
- iv  output  32  committed IV
- key_valid  output  1  key/iv hold a complete, error-free load
- load_done  output  1  one-cycle pulse when a load finishes (with or without error)
- err  output  1  sticky format error of the last load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; key=0, iv=0, staging=0, word count=0.
  - key_valid=0, load_done=0, err=0, din_ready=0.
- States:
  - IDLE: din_ready=0.
    - start=1, iv_only=0 → KEY, count=0; key_valid cleared and err cleared on the same edge.
    - start=1, iv_only=1, key_valid=1 → IV; err cleared; key_valid stays 1.
    - start=1, iv_only=1, key_valid=0 → ignored; stay in IDLE, no flag change.
  - KEY: din_ready=1. Each accepted word (din_valid & din_ready) is written to staging bits [32*count+31 : 32*count], then count increments.
    - Word 5 is special: only din[28:0] maps to key[188:160]. If din[31:29]≠0, an internal error flag is set; the word is still accepted.
    - After word 5 is accepted → IV.
  - IV: din_ready=1. Accepting one word ends the load; next state is IDLE.
- Commit, on the edge that accepts the IV word:
  - Error flag clear: key←staging (full load only; a reseed leaves key unchanged), iv←din, key_valid←1.
  - Error flag set: key/iv unchanged, key_valid stays 0, err←1.
  - In both cases load_done=1 for exactly the next cycle.
- Timing:
  - start accepted at edge t → din_ready=1 from cycle t+1.
  - Throughput is one word per cycle.
  - Full load takes at least 7 accepted words; reseed takes 1.
  - din_valid low inserts stalls with no state change.
- Reset/abort/start precedence:
  - abort=1 in KEY or IV → IDLE next edge; staging discarded; key/iv unchanged.
  - An aborted full load leaves key_valid=0. An aborted reseed leaves key_valid=1.
  - No load_done pulse on abort. err is not set by abort.
  - abort and din_valid in the same cycle: abort wins and the word is not accepted (din_ready is forced to 0 that cycle).
  - start while in KEY or IV is ignored.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: start wins.
- Count wraps only via the state transition; it never exceeds 5.
- err stays high until the next accepted start.

Test Plan:
- Reset then full load:
  - Stimulus: words 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555, 0x1ABCDEF0, IV 0xDEADBEEF, back-to-back.
  - Required: key[95:0]=0x333333332222222211111111, key[188:160]=0x1ABCDEF0, iv=0xDEADBEEF, key_valid=1.
  - Required: load_done pulses exactly 1 cycle, 8 cycles after the start edge.
- Stalled full load, din_valid toggled 1/0 every cycle:
  - Required: same result as the back-to-back load; load_done appears only after the 7th accepted word.
- Format error, word 5 = 0xE0000000:
  - Required: load_done=1, err=1, key_valid=0, key/iv still hold their prior values.
  - Required: the next full start clears err.
- Reseed after a good load with IV 0x0000FFFF:
  - Required: iv=0x0000FFFF, key unchanged, key_valid stays 1 throughout, load_done 2 cycles after start.
- Reseed with key_valid=0:
  - Required: start ignored, din_ready stays 0, no load_done.
- Abort after word 3 of a full load, and rst_n pulled low mid-load:
  - Abort required: IDLE, key_valid=0, no load_done, old key/iv retained.
  - Reset required: all outputs 0 immediately (asynchronously).
